spi_mem_arbiter: RTL and testbench
==================================

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter PCM_BURST_MAX, default 4: max consecutive PCM grants while CPU waits; legal range 1..15.
REQ-002 Parameter AW, default 24: memory address width.
REQ-003 clk_24m  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cpu_valid  in  1  CPU request; held high by requester until cpu_ready.
REQ-006 cpu_addr  in  AW  CPU byte address.
REQ-007 cpu_we  in  1  CPU write enable.
REQ-008 cpu_wdata  in  32  CPU write data.
REQ-009 cpu_select  in  1  CPU chip select: 0 flash, 1 PSRAM.
REQ-010 cpu_ready  out  1  CPU transfer complete; single-cycle pulse.
REQ-011 cpu_rdata  out  32  CPU read data; valid while cpu_ready high.
REQ-012 pcm_valid  in  1  PCM sample fetch request; held until pcm_ready.
REQ-013 pcm_addr  in  AW  PCM byte address.
REQ-014 pcm_ready  out  1  PCM transfer complete; single-cycle pulse.
REQ-015 pcm_rdata  out  8  PCM byte; valid while pcm_ready high.
REQ-016 mem_valid, mem_we, mem_addr[AW], mem_wdata[32], mem_length[2], mem_select  out  downstream request to SPI memory controller.
REQ-017 mem_ready  in  1  downstream completion; mem_rdata  in  32  downstream read data.
REQ-018 grant_pcm  out  1  high while PCM owns the memory port (debug/status).

Function
REQ-019 FSM states IDLE, CPU_BUSY, PCM_BUSY; registered state.
REQ-020 IDLE: no request -> stay IDLE.
REQ-021 IDLE: only cpu_valid -> CPU_BUSY; only pcm_valid -> PCM_BUSY.
REQ-022 IDLE, both valid: PCM_BUSY if streak < PCM_BURST_MAX, otherwise CPU_BUSY.
REQ-023 streak: 4-bit counter; +1 (saturating) on each PCM grant taken while cpu_valid high; cleared on any CPU grant; cleared in IDLE when cpu_valid low.
REQ-024 On the IDLE->busy edge the granted port's addr/we/wdata/select are latched into output registers; mem_* stay stable for the whole transaction regardless of requester input changes.
REQ-025 mem_valid = (state != IDLE); first assertion one cycle after the grant decision.
REQ-026 CPU grant: mem_we = latched cpu_we, mem_length = 2'b11, mem_select = latched cpu_select, mem_wdata = latched cpu_wdata.
REQ-027 PCM grant: mem_we = 0, mem_length = 2'b00, mem_select = 1, mem_wdata = 0.
REQ-028 Busy state with mem_ready high -> IDLE at next edge; mem_valid therefore deasserts the cycle after mem_ready.
REQ-029 cpu_ready = mem_ready & CPU_BUSY; pcm_ready = mem_ready & PCM_BUSY; combinational, same cycle as mem_ready.
REQ-030 cpu_rdata = mem_rdata; pcm_rdata = mem_rdata[7:0]; both are don't-care outside their ready pulses.
REQ-031 mem_ready while IDLE is ignored; no ready pulse, no state change.
REQ-032 At least one IDLE cycle separates consecutive transactions; grant is never re-decided mid-transaction.
REQ-033 Requester valid dropped mid-transaction does not abort; transaction completes; ready still pulses.
REQ-034 grant_pcm = (state == PCM_BUSY).

Reset
REQ-035 rst high: state IDLE, streak 0, latched request registers 0.
REQ-036 During reset: mem_valid 0, cpu_ready 0, pcm_ready 0, grant_pcm 0.
REQ-037 rst asserted mid-transaction aborts immediately; mem_valid drops without waiting for mem_ready.
REQ-038 First grant decision is made in the first IDLE cycle after rst deasserts.

Verification
REQ-039 CPU-only read: cpu_valid, addr 0x001234, select 1; mem_ready after 5 cycles -> mem_valid 1 cycle after request, mem_length 2'b11, cpu_ready 1 cycle, cpu_rdata = mem_rdata.
REQ-040 Simultaneous CPU+PCM, streak 0 -> PCM granted first (mem_length 2'b00, mem_we 0); CPU granted after PCM mem_ready plus 1 IDLE cycle.
REQ-041 Starvation: PCM and CPU both held continuously, PCM_BURST_MAX=4 -> grant order P,P,P,P,C,P,P,P,P,C.
REQ-042 Requester changes cpu_addr/cpu_wdata while CPU_BUSY -> mem_addr/mem_wdata unchanged until completion.
REQ-043 rst pulsed while PCM_BUSY before mem_ready -> mem_valid 0 and grant_pcm 0 within the reset cycle; after release a pending cpu_valid is granted.
REQ-044 Spurious mem_ready in IDLE -> no cpu_ready or pcm_ready pulse, state remains IDLE.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
// Shares one SPI memory controller port between a CPU requester and a PCM
// sample fetcher. PCM normally wins a tie, but a streak counter bounds how
// many PCM grants can be taken back-to-back while the CPU is waiting.
// The winning request is captured on the grant edge so the downstream
// request stays stable for the whole transaction.

module spi_mem_arbiter #(
    parameter int PCM_BURST_MAX = 4,
    parameter int AW            = 24
) (
    input  logic          clk_24m,
    input  logic          rst,

    input  logic          cpu_valid,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_wdata,
    input  logic          cpu_select,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,

    input  logic          pcm_valid,
    input  logic [AW-1:0] pcm_addr,
    output logic          pcm_ready,
    output logic [7:0]    pcm_rdata,

    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [1:0]    mem_length,
    output logic          mem_select,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata,

    output logic          grant_pcm
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_PCM  = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX_C = 4'(PCM_BURST_MAX);

    // Streak counter stops at its ceiling instead of wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) begin
            r = 4'd15;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    state_t          state_q,  state_d;
    logic [3:0]      streak_q, streak_d;
    logic [AW-1:0]   addr_q,   addr_d;
    logic            we_q,     we_d;
    logic [31:0]     wdata_q,  wdata_d;
    logic [1:0]      length_q, length_d;
    logic            select_q, select_d;

    // State, streak and captured request registers.
    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            streak_q <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            length_q <= 2'b00;
            select_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            length_q <= length_d;
            select_q <= select_d;
        end
    end

    // Grant decision in IDLE, completion tracking while busy.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        length_d = length_q;
        select_d = select_q;

        case (state_q)
            ST_IDLE: begin
                if (!cpu_valid) begin
                    streak_d = 4'd0;
                end else begin
                    streak_d = streak_q;
                end

                // CPU wins when it is alone or when PCM has used up its burst.
                if (cpu_valid && (!pcm_valid || (streak_q >= BURST_MAX_C))) begin
                    state_d  = ST_CPU;
                    streak_d = 4'd0;
                    addr_d   = cpu_addr;
                    we_d     = cpu_we;
                    wdata_d  = cpu_wdata;
                    length_d = 2'b11;
                    select_d = cpu_select;
                end else if (pcm_valid) begin
                    state_d  = ST_PCM;
                    addr_d   = pcm_addr;
                    we_d     = 1'b0;
                    wdata_d  = 32'd0;
                    length_d = 2'b00;
                    select_d = 1'b1;
                    // Only grants that made the CPU wait count toward the burst.
                    if (cpu_valid) begin
                        streak_d = sat_inc(streak_q);
                    end else begin
                        streak_d = 4'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CPU, ST_PCM: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Downstream request is driven straight from the captured registers.
    always_comb begin
        mem_valid  = (state_q != ST_IDLE);
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_length = length_q;
        mem_select = select_q;
        grant_pcm  = (state_q == ST_PCM);
    end

    // Completion pulses follow mem_ready in the same cycle; read data passes through.
    always_comb begin
        cpu_ready = mem_ready & (state_q == ST_CPU);
        pcm_ready = mem_ready & (state_q == ST_PCM);
        cpu_rdata = mem_rdata;
        pcm_rdata = mem_rdata[7:0];
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Table-driven bench for spi_mem_arbiter with hand-written sequences for
// the burst limit and mid-transaction reset cases.

module tb_spi_mem_arbiter;

    logic        clk_24m = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_we, cpu_select;
    logic [23:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        pcm_valid;
    logic [23:0] pcm_addr;
    logic        pcm_ready;
    logic [7:0]  pcm_rdata;
    logic        mem_valid, mem_we, mem_select;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_length;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        grant_pcm;

    int errors = 0;
    int checks = 0;

    spi_mem_arbiter #(.PCM_BURST_MAX(4), .AW(24)) dut (
        .clk_24m    (clk_24m),
        .rst        (rst),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_select (cpu_select),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .pcm_valid  (pcm_valid),
        .pcm_addr   (pcm_addr),
        .pcm_ready  (pcm_ready),
        .pcm_rdata  (pcm_rdata),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_length (mem_length),
        .mem_select (mem_select),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .grant_pcm  (grant_pcm)
    );

    always #20 clk_24m = ~clk_24m;

    typedef struct {
        logic        cv;
        logic        cwe;
        logic        csel;
        logic [23:0] caddr;
        logic [31:0] cwd;
        logic        pv;
        logic [23:0] paddr;
        logic        mrdy;
        logic [31:0] mrd;
        logic        e_mv;
        logic        e_gp;
        logic        e_cr;
        logic        e_pr;
        logic [1:0]  e_len;
        logic        e_we;
        logic        e_sel;
        logic [23:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk_24m);
        #1;
    endtask

    initial begin
        logic [9:0] exp_gp;
        int         cnt;

        rst = 1'b1;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_select = 1'b0;
        cpu_addr = 24'h0; cpu_wdata = 32'h0;
        pcm_valid = 1'b0; pcm_addr = 24'h0;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;

        // ---- vector table ----
        // idle, spurious mem_ready in idle
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b1,32'hDEAD_BEEF,  1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        // CPU-only read, PSRAM, ready five cycles after the request
        vecs.push_back('{1'b1,1'b0,1'b1,24'h001234,32'h0, 1'b0,24'h0, 1'b0,32'h0,     1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        for (int k = 0; k < 4; k++) begin
            vecs.push_back('{1'b1,1'b0,1'b1,24'h001234,32'h0, 1'b0,24'h0, 1'b0,32'h0, 1'b1,1'b0,1'b0,1'b0, 2'b11,1'b0,1'b1,24'h001234,32'h0,32'h0});
        end
        vecs.push_back('{1'b1,1'b0,1'b1,24'h001234,32'h0, 1'b0,24'h0, 1'b1,32'hCAFE_F00D, 1'b1,1'b0,1'b1,1'b0, 2'b11,1'b0,1'b1,24'h001234,32'h0,32'hCAFE_F00D});
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        // simultaneous CPU write + PCM: PCM first, CPU after one idle cycle
        vecs.push_back('{1'b1,1'b1,1'b0,24'h00ABC0,32'h1122_3344, 1'b1,24'h000100, 1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        vecs.push_back('{1'b1,1'b1,1'b0,24'h00ABC0,32'h1122_3344, 1'b1,24'h000100, 1'b0,32'h0, 1'b1,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b1,24'h000100,32'h0,32'h0});
        vecs.push_back('{1'b1,1'b1,1'b0,24'h00ABC0,32'h1122_3344, 1'b1,24'h000100, 1'b1,32'h0000_01A5, 1'b1,1'b1,1'b0,1'b1, 2'b00,1'b0,1'b1,24'h000100,32'h0,32'h0000_00A5});
        vecs.push_back('{1'b1,1'b1,1'b0,24'h00ABC0,32'h1122_3344, 1'b0,24'h0, 1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        // requester changes addr/wdata while CPU busy: captured values hold
        vecs.push_back('{1'b1,1'b0,1'b1,24'hFFFFFF,32'h5555_5555, 1'b0,24'h0, 1'b0,32'h0, 1'b1,1'b0,1'b0,1'b0, 2'b11,1'b1,1'b0,24'h00ABC0,32'h1122_3344,32'h0});
        vecs.push_back('{1'b1,1'b0,1'b1,24'hFFFFFF,32'h5555_5555, 1'b0,24'h0, 1'b1,32'h1234_5678, 1'b1,1'b0,1'b1,1'b0, 2'b11,1'b1,1'b0,24'h00ABC0,32'h1122_3344,32'h1234_5678});
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        // PCM drops valid mid-transaction: still completes with a ready pulse
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b1,24'h0000FF, 1'b0,32'h0,     1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b0,32'h0,          1'b1,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b1,24'h0000FF,32'h0,32'h0});
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b1,32'h0000_3C7E, 1'b1,1'b1,1'b0,1'b1, 2'b00,1'b0,1'b1,24'h0000FF,32'h0,32'h0000_007E});
        vecs.push_back('{1'b0,1'b0,1'b0,24'h0,32'h0, 1'b0,24'h0, 1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,24'h0,32'h0,32'h0});

        // ---- reset state ----
        wait_cycle();
        wait_cycle();
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_grant_pcm", {31'd0, grant_pcm}, 32'd0);
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_pcm_ready", {31'd0, pcm_ready}, 32'd0);
        chk("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        mem_ready = 1'b0;
        rst = 1'b0;

        // ---- apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            wait_cycle();
            cpu_valid = vecs[i].cv;   cpu_we = vecs[i].cwe; cpu_select = vecs[i].csel;
            cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            pcm_valid = vecs[i].pv;   pcm_addr = vecs[i].paddr;
            mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrd;
            #1;
            chk($sformatf("v%0d_mem_valid", i), {31'd0, mem_valid}, {31'd0, vecs[i].e_mv});
            chk($sformatf("v%0d_grant_pcm", i), {31'd0, grant_pcm}, {31'd0, vecs[i].e_gp});
            chk($sformatf("v%0d_cpu_ready", i), {31'd0, cpu_ready}, {31'd0, vecs[i].e_cr});
            chk($sformatf("v%0d_pcm_ready", i), {31'd0, pcm_ready}, {31'd0, vecs[i].e_pr});
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d_mem_length", i), {30'd0, mem_length}, {30'd0, vecs[i].e_len});
                chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
                chk($sformatf("v%0d_mem_select", i), {31'd0, mem_select}, {31'd0, vecs[i].e_sel});
                chk($sformatf("v%0d_mem_addr", i), {8'd0, mem_addr}, {8'd0, vecs[i].e_addr});
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wd);
            end
            if (vecs[i].e_cr) begin
                chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
            end
            if (vecs[i].e_pr) begin
                chk($sformatf("v%0d_pcm_rdata", i), {24'd0, pcm_rdata}, vecs[i].e_rd);
            end
        end

        // ---- burst limit: both held, expect P,P,P,P,C,P,P,P,P,C ----
        wait_cycle();
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_select = 1'b0; cpu_addr = 24'h000040;
        pcm_valid = 1'b1; pcm_addr = 24'h000200; mem_ready = 1'b0;
        exp_gp = 10'b0111101111;
        for (int t = 0; t < 10; t++) begin
            cnt = 0;
            while (!mem_valid && cnt < 8) begin
                wait_cycle();
                cnt++;
            end
            chk($sformatf("burst%0d_mem_valid", t), {31'd0, mem_valid}, 32'd1);
            chk($sformatf("burst%0d_grant_pcm", t), {31'd0, grant_pcm}, {31'd0, exp_gp[t]});
            mem_ready = 1'b1; mem_rdata = 32'h100 + 32'(t);
            #1;
            chk($sformatf("burst%0d_cpu_ready", t), {31'd0, cpu_ready}, {31'd0, ~exp_gp[t]});
            chk($sformatf("burst%0d_pcm_ready", t), {31'd0, pcm_ready}, {31'd0, exp_gp[t]});
            wait_cycle();
            mem_ready = 1'b0;
            chk($sformatf("burst%0d_idle_gap", t), {31'd0, mem_valid}, 32'd0);
        end
        cpu_valid = 1'b0; pcm_valid = 1'b0;
        wait_cycle();

        // ---- reset while PCM busy, then pending CPU granted ----
        pcm_valid = 1'b1; pcm_addr = 24'h000333;
        wait_cycle();
        chk("rstmid_pcm_granted", {31'd0, grant_pcm}, 32'd1);
        cpu_valid = 1'b1; cpu_addr = 24'h000777; cpu_we = 1'b1;
        cpu_wdata = 32'hA5A5_A5A5; cpu_select = 1'b0;
        #5;
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rstmid_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rstmid_grant_pcm", {31'd0, grant_pcm}, 32'd0);
        chk("rstmid_pcm_ready", {31'd0, pcm_ready}, 32'd0);
        chk("rstmid_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        wait_cycle();
        mem_ready = 1'b0; pcm_valid = 1'b0; rst = 1'b0;
        #1;
        chk("rstrel_idle", {31'd0, mem_valid}, 32'd0);
        wait_cycle();
        chk("rstrel_cpu_valid", {31'd0, mem_valid}, 32'd1);
        chk("rstrel_grant_pcm", {31'd0, grant_pcm}, 32'd0);
        chk("rstrel_length", {30'd0, mem_length}, 32'd3);
        chk("rstrel_addr", {8'd0, mem_addr}, 32'h000777);
        chk("rstrel_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        #1;
        chk("rstrel_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rstrel_cpu_rdata", cpu_rdata, 32'h0BAD_CAFE);
        wait_cycle();
        mem_ready = 1'b0; cpu_valid = 1'b0;
        chk("rstrel_done", {31'd0, mem_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
